ram_check_fsm: RTL and testbench

Reader-side counterpart to the S-memory initialisation writer. On a start pulse it sweeps the 256-entry S memory read port from address 0 to 255. It compares each returned byte against its address, which is the identity permutation the initialiser writes, and reports the result. It reports a pass flag, a mismatch count and the first failing address, then signals completion with a one-cycle fin_strobe. The block sits beside the writer behind the memory address mux and is used as a bring-up/self-test stage before key scheduling.

---
 rtl/ram_check_fsm_if.sv | 26 ++
 rtl/ram_check_fsm.sv | 155 +++++++++++++++
 tb/tb_ram_check_fsm.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ram_check_fsm_if.sv
// Bus between the S-memory read checker and its environment.
// The master side is the checker. It drives the read address and the
// status/results. The slave side is the controller plus the memory,
// which drive start and rd_data.
interface ram_check_fsm_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] address;
   logic [ADDR_W-1:0] rd_data;
   logic              busy;
   logic              fin_strobe;
   logic              pass;
   logic [ADDR_W:0]   err_count;
   logic [ADDR_W-1:0] first_err_addr;

   modport master (
      input  start, rd_data,
      output address, busy, fin_strobe, pass, err_count, first_err_addr
   );

   modport slave (
      output start, rd_data,
      input  address, busy, fin_strobe, pass, err_count, first_err_addr
   );
endinterface

// File: rtl/ram_check_fsm.sv
// S-memory self-test reader.
// On start, the block sweeps the read port over every address. It checks
// that each returned byte equals its own address, which is the identity
// permutation. At the end it reports pass, the mismatch count and the
// first failing address, and pulses fin_strobe for one cycle.
module ram_check_fsm #(
   parameter int ADDR_W     = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic clk,
   input  logic rst,
   ram_check_fsm_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
   localparam int                DW         = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [DW-1:0]     DRAIN_LAST = DW'(RD_LATENCY - 1);

   state_t            state_q;
   logic [ADDR_W-1:0] address_q;
   logic              busy_q;
   logic              fin_q;
   logic              pass_q;
   logic [ADDR_W:0]   err_q;
   logic [ADDR_W-1:0] first_q;
   logic [DW-1:0]     drain_q;

   // Compare pipeline. Each entry carries the address that was issued,
   // aligned with the memory read latency.
   logic              vld_q [RD_LATENCY];
   logic [ADDR_W-1:0] tag_q [RD_LATENCY];

   logic              cmp_valid;
   logic [ADDR_W-1:0] cmp_tag;
   logic              mismatch;
   logic [ADDR_W:0]   err_d;
   logic [ADDR_W-1:0] first_d;

   assign cmp_valid = vld_q[RD_LATENCY-1];
   assign cmp_tag   = tag_q[RD_LATENCY-1];
   assign mismatch  = cmp_valid && (bus.rd_data != cmp_tag);

   // Next error count and first failing address from the compare at the chain output
   always_comb begin
      err_d   = err_q;
      first_d = first_q;
      if (mismatch) begin
         err_d = err_q + 1'b1;
         if (err_q == '0) begin
            first_d = cmp_tag;
         end
      end
   end

   // Stage 0: issue one entry for every cycle spent in READ
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q[0] <= 1'b0;
         tag_q[0] <= '0;
      end else begin
         vld_q[0] <= (state_q == S_READ);
         tag_q[0] <= address_q;
      end
   end

   generate
      for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_stage
         // Later stages: plain delay so the tag lines up with rd_data
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_q[gi] <= 1'b0;
               tag_q[gi] <= '0;
            end else begin
               vld_q[gi] <= vld_q[gi-1];
               tag_q[gi] <= tag_q[gi-1];
            end
         end
      end
   endgenerate

   // Sweep sequencer with registered outputs and result accumulation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         address_q <= '0;
         busy_q    <= 1'b0;
         fin_q     <= 1'b0;
         pass_q    <= 1'b0;
         err_q     <= '0;
         first_q   <= '0;
         drain_q   <= '0;
      end else begin
         // The chain is empty in IDLE and DONE, so this update is a
         // hold in those states.
         err_q   <= err_d;
         first_q <= first_d;
         case (state_q)
            S_IDLE: begin
               fin_q <= 1'b0;
               if (bus.start) begin
                  state_q   <= S_READ;
                  address_q <= '0;
                  err_q     <= '0;
                  first_q   <= '0;
                  pass_q    <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            S_READ: begin
               if (address_q == ADDR_MAX) begin
                  // Address holds at max. No wrap is issued.
                  state_q <= S_DRAIN;
                  drain_q <= '0;
               end else begin
                  address_q <= address_q + 1'b1;
               end
            end
            S_DRAIN: begin
               if (drain_q == DRAIN_LAST) begin
                  // The final compare happens on this edge, so the
                  // verdict is taken from err_d.
                  state_q <= S_DONE;
                  fin_q   <= 1'b1;
                  pass_q  <= (err_d == '0);
               end else begin
                  drain_q <= drain_q + 1'b1;
               end
            end
            S_DONE: begin
               fin_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.address        = address_q;
   assign bus.busy           = busy_q;
   assign bus.fin_strobe     = fin_q;
   assign bus.pass           = pass_q;
   assign bus.err_count      = err_q;
   assign bus.first_err_addr = first_q;

endmodule

// File: tb/tb_ram_check_fsm.sv
// Directed bench for ram_check_fsm.
// dut1 runs with RD_LATENCY=1 and dut2 with RD_LATENCY=2. Each DUT has
// its own behavioural memory whose read latency matches its parameter.
module tb_ram_check_fsm;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_check_fsm_if #(.ADDR_W(8)) bus1 ();
   ram_check_fsm_if #(.ADDR_W(8)) bus2 ();

   ram_check_fsm #(.ADDR_W(8), .RD_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   ram_check_fsm #(.ADDR_W(8), .RD_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   logic [7:0] mem1 [256];
   logic [7:0] mem2 [256];
   logic [7:0] mem2_stage;

   // Memory 1: address registered, q unregistered, so one edge of latency
   always @(posedge clk) bus1.rd_data <= mem1[bus1.address];

   // Memory 2: one extra output register, so two edges of latency
   always @(posedge clk) begin
      mem2_stage   <= mem2[bus2.address];
      bus2.rd_data <= mem2_stage;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("check %-18s got=%0d exp=%0d ok", tag, got, exp);
      end else begin
         $display("FAIL %-18s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Pulse start for one edge (E0). Return the number of edges after E0
   // at which fin_strobe is first seen high. Sampling is on the negedge.
   task automatic run_sweep(input bit sel, output int edges);
      @(negedge clk);
      if (sel) bus2.start = 1'b1; else bus1.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      edges = 0;
      while (!(sel ? bus2.fin_strobe : bus1.fin_strobe) && edges < 600) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
   endtask

   initial begin
      int e;
      int n;
      int fins;
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem1[i] = 8'(i);
         mem2[i] = 8'(i);
      end

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_address", 32'(bus1.address), 0);
      check("rst_busy", 32'(bus1.busy), 0);
      check("rst_fin", 32'(bus1.fin_strobe), 0);
      check("rst_pass", 32'(bus1.pass), 0);
      check("rst_err", 32'(bus1.err_count), 0);
      check("rst_first", 32'(bus1.first_err_addr), 0);
      rst = 1'b0;

      // Identity contents
      run_sweep(1'b0, e);
      check("id_edges", 32'(e), 257);
      check("id_busy_done", 32'(bus1.busy), 1);
      check("id_pass", 32'(bus1.pass), 1);
      check("id_err", 32'(bus1.err_count), 0);
      check("id_first", 32'(bus1.first_err_addr), 0);
      @(negedge clk);
      check("id_fin_1cyc", 32'(bus1.fin_strobe), 0);
      check("id_busy_after", 32'(bus1.busy), 0);

      // Two corruptions
      mem1[8'h37] = 8'h00;
      mem1[8'hC8] = 8'hFF;
      run_sweep(1'b0, e);
      check("two_edges", 32'(e), 257);
      check("two_pass", 32'(bus1.pass), 0);
      check("two_err", 32'(bus1.err_count), 2);
      check("two_first", 32'(bus1.first_err_addr), 32'h37);
      repeat (5) @(negedge clk);
      check("two_hold_err", 32'(bus1.err_count), 2);
      check("two_hold_first", 32'(bus1.first_err_addr), 32'h37);

      // All zeros
      for (int i = 0; i < 256; i++) mem1[i] = 8'h00;
      run_sweep(1'b0, e);
      check("zero_err", 32'(bus1.err_count), 255);
      check("zero_first", 32'(bus1.first_err_addr), 1);
      check("zero_pass", 32'(bus1.pass), 0);
      check("zero_addr", 32'(bus1.address), 32'hFF);

      // Start held high: back-to-back sweeps 259 cycles apart
      for (int i = 0; i < 256; i++) mem1[i] = 8'(i);
      @(negedge clk);
      bus1.start = 1'b1;
      n = 0;
      while (!bus1.fin_strobe && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("held_first_fin", 32'(bus1.fin_strobe), 1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus1.fin_strobe && n < 600);
      bus1.start = 1'b0;
      check("held_period", 32'(n), 259);
      check("held_err", 32'(bus1.err_count), 0);
      check("held_pass", 32'(bus1.pass), 1);

      // Asynchronous reset in the middle of a sweep
      @(negedge clk);
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      n = 0;
      while (bus1.address != 8'd100 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("mid_addr100", 32'(bus1.address), 100);
      #2 rst = 1'b1;
      #1;
      check("async_address", 32'(bus1.address), 0);
      check("async_busy", 32'(bus1.busy), 0);
      check("async_pass", 32'(bus1.pass), 0);
      check("async_err", 32'(bus1.err_count), 0);
      @(negedge clk);
      rst = 1'b0;
      fins = 0;
      repeat (300) begin
         @(negedge clk);
         if (bus1.fin_strobe) fins++;
      end
      check("abort_no_fin", 32'(fins), 0);
      run_sweep(1'b0, e);
      check("post_rst_edges", 32'(e), 257);
      check("post_rst_pass", 32'(bus1.pass), 1);

      // Two-cycle memory
      run_sweep(1'b1, e);
      check("lat2_edges", 32'(e), 258);
      check("lat2_pass", 32'(bus2.pass), 1);
      check("lat2_err", 32'(bus2.err_count), 0);
      mem2[8'hFF] = 8'h00;
      run_sweep(1'b1, e);
      check("lat2_c_edges", 32'(e), 258);
      check("lat2_c_err", 32'(bus2.err_count), 1);
      check("lat2_c_first", 32'(bus2.first_err_addr), 32'hFF);
      check("lat2_c_pass", 32'(bus2.pass), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
